chip8_timers: RTL and testbench
===============================

Name: chip8_timers

Overview:
- Implements the CHIP-8 delay timer (DT) and sound timer (ST). Each is an 8-bit down-counter that decrements at 60 Hz.
- The 60 Hz rate arrives as a free-running divided square wave, `tick_in`, produced by the upstream clock divider. This block consumes it as data, not as a clock.
- The CPU core loads both timers (Fx15 / Fx18) and reads back DT (Fx07).
- While ST is non-zero, the block drives a gated square-wave tone for the speaker.

Parameters:
- DATA_W, 8, width of each timer register; CHIP-8 requires 8.
- TONE_HALF, 1000, number of clk_in cycles per half-period of the tone output; minimum 1.

Ports:
- clk_in  input  1  system clock; all state is on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is immediate, release is synchronous to clk_in.
- tick_in  input  1  60 Hz divided clock from the upstream divider; treated as asynchronous.
- dt_we  input  1  load DT from wdata this cycle.
- st_we  input  1  load ST from wdata this cycle.
- wdata  input  DATA_W  value to load.
- dt_q  output  DATA_W  current DT value (register output).
- st_q  output  DATA_W  current ST value (register output).
- sound_on  output  1  high while ST != 0.
- tone  output  1  speaker square wave; 0 when sound_on is low.
- tick_pulse  output  1  one-cycle strobe on each detected tick_in rise; for debug and for other consumers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser flops, edge-detect flop, dt_q, st_q, tone and the tone counter all clear to 0.
  - Consequently sound_on=0, tone=0 and tick_pulse=0.
  - Reset asserted mid-countdown aborts the countdown immediately, with no residual tone.
- Tick detection:
  - tick_in passes through a 2-flop synchroniser (s1, s2) and then a history flop s3.
  - tick_pulse = s2 & ~s3.
  - A rising edge of tick_in produces exactly one tick_pulse cycle, 2–3 clk_in cycles later.
  - A falling edge produces no pulse. A held-high tick_in produces only one pulse.
  - After reset release with tick_in already high, one pulse fires once the synchroniser fills; this is accepted.
- Timer update (DT and ST independently), priority high to low:
  1. Write enable high: the register loads wdata at the next edge. A tick_pulse in the same cycle is ignored for that timer (the write wins; no decrement is applied to the new value).
  2. tick_pulse high and register != 0: the register decrements by 1.
  3. Otherwise: hold.
- Timer boundary and simultaneous-event rules:
  - A register at 0 never wraps to 255; it saturates at 0.
  - dt_we and st_we may both be high in one cycle; both timers load the same wdata.
  - A write of 0 stops the timer immediately.
- Output timing:
  - dt_q and st_q reflect a write 1 cycle after the write cycle, and a decrement 1 cycle after tick_pulse.
  - sound_on is combinational: (st_q != 0).
- Tone generator:
  - Counter width is $clog2(TONE_HALF)+1.
  - While sound_on=0, the counter is held at 0 and tone=0.
  - While sound_on=1, the counter increments each cycle. On reaching TONE_HALF-1 it wraps to 0 and tone toggles.
  - The first toggle to 1 occurs TONE_HALF cycles after sound_on rises. The period is 2*TONE_HALF cycles; the duty cycle is 50%.
  - When sound_on falls, tone returns to 0 on the next edge and the counter clears, so every beep starts in a known phase.
- No read handshake: dt_q is always valid. A CPU read in the same cycle as a tick_pulse sees the pre-decrement value.

Test Plan:
- Reset with tick_in toggling, then release → dt_q=st_q=0, sound_on=0, tone=0. Exactly one tick_pulse per tick_in rise, 2–3 cycles after the edge.
- Load: dt_we with wdata=3, then 4 tick_in rises → dt_q steps 3,2,1,0,0; no wrap to 255.
- st_we with wdata=2, TONE_HALF=4 → sound_on high the cycle after the write. tone is 0 for 4 cycles, then toggles every 4 cycles. After 2 ticks, st_q=0, sound_on=0, and tone=0 on the next edge.
- dt_we with wdata=10 coincident with tick_pulse while dt_q=5 → dt_q=10 next cycle, not 9 or 4. The next tick gives 9.
- dt_we and st_we both high with wdata=0x80 → both read 0x80; one tick → both 0x7F. st_we with wdata=0 → sound_on drops the next cycle.
- Set st_q=50 and let tone run, then assert rst_n mid-half-period → st_q, tone and sound_on are 0 immediately (asynchronously). After release, no tone appears until a new st_we.

Source files
------------

// File: rtl/chip8_timers_if.sv
// CPU-side register interface of the CHIP-8 delay/sound timers.
//   dt_we, st_we : load strobes for DT / ST (driven by the CPU)
//   wdata        : value loaded by either strobe
//   dt_q, st_q   : current timer values (driven by the timer block)
// The master modport is the CPU and the slave modport is the timer block.
interface chip8_timers_if #(
  parameter int DATA_W = 8
);
  logic              dt_we;
  logic              st_we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] dt_q;
  logic [DATA_W-1:0] st_q;

  modport master (
    output dt_we, st_we, wdata,
    input  dt_q, st_q
  );

  modport slave (
    input  dt_we, st_we, wdata,
    output dt_q, st_q
  );
endinterface

// File: rtl/chip8_timers.sv
// CHIP-8 delay timer (DT) and sound timer (ST) with a gated speaker tone.
//   clk_in     : system clock
//   rst_n      : asynchronous active-low reset
//   tick_in    : 60 Hz square wave from the upstream divider, asynchronous
//   bus        : CPU load strobes, load data and timer readback
//   sound_on   : high while ST is non-zero
//   tone       : square wave with 2*TONE_HALF cycle period while sound_on, else 0
//   tick_pulse : one-cycle strobe per detected tick_in rising edge
module chip8_timers #(
  parameter int DATA_W    = 8,
  parameter int TONE_HALF = 1000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 tick_in,
  chip8_timers_if.slave        bus,
  output logic                 sound_on,
  output logic                 tone,
  output logic                 tick_pulse
);

  localparam int CNT_W = $clog2(TONE_HALF) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_HALF - 1);

  logic s1, s2, s3;
  logic [DATA_W-1:0] dt_r, st_r;
  logic [CNT_W-1:0]  tone_cnt;
  logic              tone_r;

  // s1/s2 synchronise tick_in; s3 holds the previous synchronised level
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_pulse = s2 & ~s3;

  // A load takes priority over a coincident tick; zero saturates
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dt_r <= '0;
    end else if (bus.dt_we) begin
      dt_r <= bus.wdata;
    end else if (tick_pulse && (dt_r != '0)) begin
      dt_r <= dt_r - DATA_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st_r <= '0;
    end else if (bus.st_we) begin
      st_r <= bus.wdata;
    end else if (tick_pulse && (st_r != '0)) begin
      st_r <= st_r - DATA_W'(1);
    end
  end

  assign bus.dt_q = dt_r;
  assign bus.st_q = st_r;
  assign sound_on = (st_r != '0);

  // Counter and tone clear while silent so every beep starts in the same phase
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      tone_r   <= 1'b0;
    end else if (!sound_on) begin
      tone_cnt <= '0;
      tone_r   <= 1'b0;
    end else if (tone_cnt == CNT_LAST) begin
      tone_cnt <= '0;
      tone_r   <= ~tone_r;
    end else begin
      tone_cnt <= tone_cnt + CNT_W'(1);
    end
  end

  assign tone = tone_r;

endmodule

// File: tb/tb_chip8_timers.sv
module tb_chip8_timers;

  localparam int TH = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic tick_in = 1'b0;
  logic sound_on, tone, tick_pulse;

  chip8_timers_if #(.DATA_W(8)) bus ();

  chip8_timers #(.DATA_W(8), .TONE_HALF(TH)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .bus        (bus.slave),
    .sound_on   (sound_on),
    .tone       (tone),
    .tick_pulse (tick_pulse)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raise tick_in, verify exactly one pulse 2-3 cycles later, then drop it
  // and verify the falling edge gives none. Called just after a negedge.
  task automatic do_tick();
    int n_rise = 0;
    int first = 0;
    int n_fall = 0;
    tick_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      if (tick_pulse) begin
        n_rise++;
        if (first == 0) first = k;
      end
    end
    check("rise_pulse_count", n_rise, 1);
    checks++;
    if (first < 2 || first > 3) begin
      errors++;
      $display("FAIL rise_pulse_latency: got %0d cycles expected 2..3", first);
    end
    tick_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      if (tick_pulse) n_fall++;
    end
    check("fall_pulse_count", n_fall, 0);
  endtask

  // Wait (bounded) for the negedge on which tick_pulse is high
  task automatic wait_pulse(output bit found);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk_in);
      if (tick_pulse) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_pulse: no tick_pulse within 6 cycles");
    end
  endtask

  task automatic write(input logic dwe, input logic swe, input logic [7:0] d);
    bus.dt_we = dwe;
    bus.st_we = swe;
    bus.wdata = d;
    @(negedge clk_in);
    bus.dt_we = 1'b0;
    bus.st_we = 1'b0;
  endtask

  typedef struct {
    logic       dt_we;
    logic       st_we;
    logic [7:0] wdata;
    logic       tick;
    logic [7:0] exp_dt;
    logic [7:0] exp_st;
    logic       exp_snd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit found;
    bus.dt_we = 1'b0;
    bus.st_we = 1'b0;
    bus.wdata = '0;

    vecs[0]  = '{1'b1, 1'b0, 8'd3,   1'b0, 8'd3,   8'd0,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd0,   1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd1,   8'd0,   1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   8'd0,   1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   8'd0,   1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd2,   1'b0, 8'd0,   8'd2,   1'b1};
    vecs[6]  = '{1'b1, 1'b1, 8'h80,  1'b0, 8'h80,  8'h80,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'd0,   1'b1, 8'h7F,  8'h7F,  1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'd0,   1'b0, 8'h7F,  8'd0,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd5,   1'b0, 8'd5,   8'd0,   1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd4,   8'd0,   1'b0};

    // Reset held while tick_in toggles
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      tick_in = ~tick_in;
      if (k == 6) begin
        check("rst_pulse", tick_pulse, 0);
        check("rst_sound", sound_on, 0);
      end
    end
    tick_in = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk_in);
    check("rst_dt", bus.dt_q, 0);
    check("rst_st", bus.st_q, 0);
    check("rst_snd", sound_on, 0);
    check("rst_tone", tone, 0);

    // Table-driven loads and ticks
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].tick) do_tick();
      else write(vecs[i].dt_we, vecs[i].st_we, vecs[i].wdata);
      check($sformatf("vec%0d_dt", i), bus.dt_q, vecs[i].exp_dt);
      check($sformatf("vec%0d_st", i), bus.st_q, vecs[i].exp_st);
      check($sformatf("vec%0d_snd", i), sound_on, vecs[i].exp_snd);
    end

    // Write coincident with tick_pulse: dt=5, load 10 on the pulse cycle
    write(1'b1, 1'b0, 8'd5);
    tick_in = 1'b1;
    wait_pulse(found);
    bus.dt_we = 1'b1;
    bus.wdata = 8'd10;
    @(negedge clk_in);
    bus.dt_we = 1'b0;
    check("coinc_dt", bus.dt_q, 10);
    tick_in = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk_in);
    do_tick();
    check("coinc_next_dt", bus.dt_q, 9);

    // Tone: ST=2, TONE_HALF=4
    bus.st_we = 1'b1;
    bus.wdata = 8'd2;
    @(negedge clk_in);
    bus.st_we = 1'b0;
    check("tone_snd_on", sound_on, 1);
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("tone_c%0d", k), tone, ((k - 1) / TH) % 2);
      @(negedge clk_in);
    end
    tick_in = 1'b1;
    wait_pulse(found);
    @(negedge clk_in);
    check("tone_st1", bus.st_q, 1);
    tick_in = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk_in);
    tick_in = 1'b1;
    wait_pulse(found);
    @(negedge clk_in);
    check("tone_st0", bus.st_q, 0);
    check("tone_snd_off", sound_on, 0);
    @(negedge clk_in);
    check("tone_off", tone, 0);
    tick_in = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk_in);

    // Asynchronous reset mid-beep
    write(1'b0, 1'b1, 8'd50);
    for (int k = 0; k < 5; k++) @(negedge clk_in);
    check("pre_rst_tone", tone, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_st", bus.st_q, 0);
    check("arst_tone", tone, 0);
    check("arst_snd", sound_on, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_in);
        if (tone || sound_on) seen++;
      end
      check("post_rst_silent", seen, 0);
    end
    write(1'b0, 1'b1, 8'd1);
    check("new_beep_snd", sound_on, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
